// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared memory-mapped bus: grants one requester,
// runs a single access with decode-miss and timeout handling, then acks it.
module bus_arbiter #(
    parameter int          N_REQ   = 2,
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 16,
    parameter int          TIMEOUT = 16,
    parameter logic [2:0]  DNONE   = 3'd7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      bus_rd,
    output logic                      bus_wr,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    input  logic                      hit,
    input  logic [2:0]                did,
    input  logic                      dev_ready,
    input  logic [DATA_W-1:0]         dev_rdata
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, win, win_nx;
    logic            found, we, miss;
    logic [TW-1:0]   timer;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        win_nx = ptr;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                found  = 1'b1;
                win_nx = PW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign miss = !hit || (did == DNONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ACCESS;
            ACCESS:  state_nx = miss ? RESP : WAIT;
            WAIT:    if (dev_ready || timer == TLAST) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            we        <= 1'b0;
            timer     <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (found) begin
                        win       <= win_nx;
                        we        <= req_we[win_nx];
                        bus_addr  <= req_addr[int'(win_nx)*ADDR_W +: ADDR_W];
                        bus_wdata <= req_wdata[int'(win_nx)*DATA_W +: DATA_W];
                    end
                end
                ACCESS: begin
                    timer <= '0;
                    if (miss) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
                WAIT: begin
                    // dev_ready takes priority over an expiring timer
                    if (dev_ready) begin
                        err   <= 1'b0;
                        rdata <= we ? '0 : dev_rdata;
                    end else if (timer == TLAST) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state != IDLE) && (win == PW'(i));
            ack[i] = (state == RESP) && (win == PW'(i));
        end
    end

    assign busy   = (state != IDLE);
    assign bus_rd = (state == ACCESS || state == WAIT) && !we;
    assign bus_wr = (state == ACCESS || state == WAIT) && we;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: transaction-level model of round-robin
// order, latency, err and rdata against a simple decoder/device model.
module tb_bus_arbiter;
    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we;
    logic [N*16-1:0] req_addr, req_wdata;
    logic [N-1:0]    gnt, ack;
    logic            err, busy, bus_rd, bus_wr, hit, dev_ready;
    logic [15:0]     rdata, bus_addr, bus_wdata, dev_rdata;
    logic [2:0]      did;

    logic [15:0]     addr_a [N];
    logic [15:0]     wdata_a [N];
    logic [7:0]      dev_lat, scnt;
    logic [15:0]     dev_data;
    int              checks = 0, errors = 0, mptr = 0;

    bus_arbiter #(.N_REQ(N), .ADDR_W(16), .DATA_W(16), .TIMEOUT(TO), .DNONE(3'd7)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .hit(hit), .did(did), .dev_ready(dev_ready),
        .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_addr[k*16 +: 16]  = addr_a[k];
            req_wdata[k*16 +: 16] = wdata_a[k];
        end
    end

    // Decoder: regions 0..6 map to device id = region, region 7 hits but
    // reports no device, regions 8..15 are unmapped.
    always_comb begin
        hit = 1'b0;
        did = 3'd7;
        if ((bus_rd || bus_wr) && bus_addr[15:12] <= 4'd7) begin
            hit = 1'b1;
            did = bus_addr[14:12];
        end
    end

    // Device answers in the dev_lat-th strobe cycle after the first.
    always @(posedge clk) scnt <= (bus_rd || bus_wr) ? scnt + 8'd1 : 8'd0;
    assign dev_ready = (bus_rd || bus_wr) && (scnt == dev_lat);
    assign dev_rdata = dev_data;

    task automatic check_txn(input string name, input int lat, input logic [15:0] data,
                             input bit drop_mid, input bit drop_end);
        int ew, cyc, strb, el;
        logic [15:0] ea, ed, erd;
        logic ewe, eerr, unm;
        logic [N-1:0] oh;
        dev_lat  = 8'(lat);
        dev_data = data;
        ew = -1;
        for (int k = 0; k < N; k++)
            if (ew < 0 && req[(mptr + k) % N]) ew = (mptr + k) % N;
        if (ew < 0) ew = 0;
        ea  = addr_a[ew];
        ed  = wdata_a[ew];
        ewe = req_we[ew];
        unm = (ea[15:12] >= 4'd7);
        el  = unm ? 1 : (lat <= TO ? 1 + lat : 1 + TO);
        eerr = unm || (lat > TO);
        erd = (!ewe && !eerr) ? data : 16'h0;
        oh = '0;
        oh[ew] = 1'b1;

        cyc = 0;
        while (gnt == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (gnt !== oh || cyc != 1) begin
            errors++;
            $display("FAIL %s grant: gnt=%b after %0d cycles, expected %b after 1", name, gnt, cyc, oh);
            return;
        end
        if (drop_mid) begin
            req[ew]     = 1'b0;
            addr_a[ew]  = 16'($urandom);
            wdata_a[ew] = 16'($urandom);
            req_we[ew]  = ~req_we[ew];
        end

        cyc  = 0;
        strb = 0;
        while (ack == 0 && cyc < 60) begin
            checks++;
            if (gnt !== oh) begin
                errors++;
                $display("FAIL %s gnt_hold: gnt=%b expected %b", name, gnt, oh);
            end
            if (bus_rd || bus_wr) begin
                strb++;
                checks++;
                if (bus_rd !== !ewe || bus_wr !== ewe || bus_addr !== ea || (ewe && bus_wdata !== ed)) begin
                    errors++;
                    $display("FAIL %s bus: rd=%b wr=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                             name, bus_rd, bus_wr, bus_addr, bus_wdata, ewe, ea, ed);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ack !== oh || cyc != el) begin
            errors++;
            $display("FAIL %s ack: ack=%b after %0d cycles, expected %b after %0d", name, ack, cyc, oh, el);
        end
        checks++;
        if (strb != el) begin
            errors++;
            $display("FAIL %s strobe_len: %0d cycles, expected %0d", name, strb, el);
        end
        checks++;
        if (err !== eerr || rdata !== erd) begin
            errors++;
            $display("FAIL %s resp: err=%b rdata=%h expected err=%b rdata=%h", name, err, rdata, eerr, erd);
        end
        checks++;
        if (gnt !== oh || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_cycle: gnt=%b rd=%b wr=%b expected gnt=%b strobes 0", name, gnt, bus_rd, bus_wr, oh);
        end
        if (drop_end) req[ew] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 0 || gnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_ack: ack=%b gnt=%b busy=%b expected all 0", name, ack, gnt, busy);
        end
        mptr = (ew + 1) % N;
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (gnt !== 0 || ack !== 0 || err !== 0 || rdata !== 0 || busy !== 0 ||
            bus_rd !== 0 || bus_wr !== 0 || bus_addr !== 0 || bus_wdata !== 0) begin
            errors++;
            $display("FAIL %s: gnt=%b ack=%b err=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wdata=%h expected all 0",
                     name, gnt, ack, err, rdata, busy, bus_rd, bus_wr, bus_addr, bus_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_released");
    endtask

    task automatic test_read();
        addr_a[0] = 16'h1234; req_we[0] = 1'b0; req = 2'b01;
        check_txn("read", 1, 16'hBEEF, 0, 1);
    endtask

    task automatic test_write();
        addr_a[1] = 16'h6FFE; wdata_a[1] = 16'hA5A5; req_we[1] = 1'b1; req = 2'b10;
        check_txn("write", 3, 16'h1111, 0, 1);
    endtask

    task automatic test_unmapped();
        addr_a[0] = 16'h8000; req_we[0] = 1'b0; req = 2'b01;
        check_txn("unmapped", 1, 16'h2222, 0, 1);
        addr_a[1] = 16'h7010; req_we[1] = 1'b1; req = 2'b10;
        check_txn("dnone", 1, 16'h3333, 0, 1);
    endtask

    task automatic test_fairness();
        addr_a[0] = 16'h0100; addr_a[1] = 16'h2200;
        req_we = 2'b01; wdata_a[0] = 16'h5A5A;
        req = 2'b11;
        for (int t = 0; t < 4; t++) check_txn("fair", 1 + t, 16'(16'hC000 + t), 0, 0);
        req = 2'b00;
    endtask

    task automatic test_timeout();
        addr_a[0] = 16'h3000; req_we[0] = 1'b0;
        req = 2'b01; check_txn("timeout_stuck", 255, 16'h4444, 0, 1);
        req = 2'b01; check_txn("ready_at_limit", TO, 16'h5555, 0, 1);
        req = 2'b01; check_txn("ready_past_limit", TO + 1, 16'h6666, 0, 1);
    endtask

    task automatic test_reset_mid();
        int cyc;
        addr_a[0] = 16'h2000; req_we[0] = 1'b0; req = 2'b01;
        check_txn("pre_reset", 1, 16'h1357, 0, 1);
        addr_a[1] = 16'h3000; req_we[1] = 1'b0; addr_a[0] = 16'h4000;
        dev_lat = 8'd255;
        req = 2'b11;
        cyc = 0;
        while (gnt == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_grant: gnt=%b expected 10", gnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus_rd !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: busy=%b rd=%b expected 1 1", busy, bus_rd);
        end
        #2 rst = 1'b1;
        #1 check_idle_zero("reset_async");
        @(negedge clk);
        check_idle_zero("reset_mid_held");
        rst = 1'b0;
        mptr = 0;
        check_txn("post_reset", 1, 16'h2468, 0, 1);
        req = 2'b00;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N; k++) begin
                addr_a[k]  = {4'($urandom_range(0, 8)), 12'($urandom)};
                wdata_a[k] = 16'($urandom);
                req_we[k]  = 1'($urandom);
            end
            req = 2'($urandom_range(1, 3));
            check_txn("random", int'($urandom_range(1, 20)), 16'($urandom),
                      1'($urandom), 1'b1);
        end
        req = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_we = '0;
        dev_lat = 8'd1;
        dev_data = '0;
        for (int k = 0; k < N; k++) begin addr_a[k] = '0; wdata_a[k] = '0; end
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_fairness();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
